cog_ram_dp: RTL and testbench
=============================

// Module: cog_ram_dp
// PURPOSE
//  Parametrised successor to the cog register RAM: one write port with byte enables, two
//  independent synchronous read ports (S and D operands fetched in one cycle).
//  Selectable read-during-write mode; hardware clear sequencer zeroes the array after reset.
//  Sits between cog decode (read addresses) and cog writeback (write port).
// PARAMETERS
//  DATA_W      32  word width; must be a multiple of 8
//  ADDR_W      9   address bits; DEPTH = 1<<ADDR_W words (512 default)
//  RDW_NEW     1   1 = read of address being written returns new (byte-merged) data; 0 = old data
//  CLEAR_ON_RES 1  1 = run clear sequence after reset; 0 = contents undefined, no busy period
// PORTS
//  clk     in   1          clock; all state on rising edge
//  res     in   1          asynchronous, active-high reset
//  busy    out  1          high while clear sequence runs; all port requests ignored
//  ena_a   in   1          read port A enable
//  a_a     in   ADDR_W     read port A address
//  q_a     out  DATA_W     read port A data (registered)
//  ena_b   in   1          read port B enable
//  a_b     in   ADDR_W     read port B address
//  q_b     out  DATA_W     read port B data (registered)
//  w       in   1          write request
//  be      in   DATA_W/8   byte enables; bit i covers d[8i+7:8i]
//  a_w     in   ADDR_W     write address
//  d       in   DATA_W     write data
// BEHAVIOUR
//  Reset (async, any state): q_a=q_b=0; clear counter=0; state=CLEAR and busy=1 if
//   CLEAR_ON_RES else state=RUN, busy=0. Reset during CLEAR restarts from address 0.
//  CLEAR: each cycle writes 0 to mem[cnt], cnt++; after writing DEPTH-1 -> RUN. Exactly
//   DEPTH cycles from res release to busy=0. q_a/q_b held at 0; ena_*, w ignored.
//  RUN, read: ena_x=1 -> q_x <= mem[a_x] next edge (latency 1); ena_x=0 -> q_x holds.
//   Ports A and B fully independent; same address on both returns identical data.
//  RUN, write: w=1 -> for each i with be[i]=1, mem[a_w] byte i <= d byte i; other bytes kept.
//   w=1 with be=0 is a no-op. Write needs no ena.
//  Read-during-write (ena_x=1, w=1, a_x==a_w, same edge): RDW_NEW=1 -> q_x = old word with
//   enabled bytes replaced by d; RDW_NEW=0 -> q_x = old word. Applies per port independently.
//  Write then read of same address on next cycle always returns written data.
//  No address out-of-range case (DEPTH = 2^ADDR_W). cnt is ADDR_W bits; terminal detect on all-ones.
// STRUCTURE
//  Package cog_ram_pkg: state enum {CLEAR, RUN}; function byte_merge(old, new, be).
//  Sub-module cog_ram_lane: one 8-bit lane, 1 write / 2 read, synchronous, read-old-data;
//   instantiated DATA_W/8 times, lane write = (w & be[i]) or clear write.
//  Top: clear FSM + counter, write-mux (clear vs user), RDW forwarding compare/merge per port.
// TESTING
//  1 Reset, CLEAR_ON_RES=1, ADDR_W=9 -> busy high exactly 512 cycles; then read 0x000,0x1FF -> 0.
//  2 RUN: w a_w=0x010 d=0xDEADBEEF be=0xF; next cycle ena_a a_a=0x010 -> q_a=0xDEADBEEF after 1 clk.
//  3 Byte enables: mem[0x020]=0x11223344, write d=0xAABBCCDD be=0x5 -> readback 0x11BB33DD.
//  4 RDW same edge, mem[0x030]=0x0, w d=0x12345678 be=0xF, ena_a=ena_b=1 a=0x030 ->
//    RDW_NEW=1: q_a=q_b=0x12345678; RDW_NEW=0: q_a=q_b=0.
//  5 Dual read: a_a=0x010, a_b=0x020 same cycle -> q_a=0xDEADBEEF, q_b=0x11BB33DD; ena_a=0
//    next cycle with new a_a -> q_a holds 0xDEADBEEF.
//  6 Assert res at clear cnt=100 -> q=0, busy stays 1, full 512-cycle clear restarts; writes
//    issued during busy leave memory 0.

Source files
------------

// File: rtl/cog_ram_pkg.sv
// Shared types and helpers for the dual-read cog register RAM.
package cog_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Selects the freshly written byte when its enable is set, otherwise keeps the stored one.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       en
    );
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/cog_ram_lane.sv
// One 8-bit slice of the register RAM: one write port, two registered read ports, read-old-data.
module cog_ram_lane #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [7:0]        wd,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] ra_a,
    output logic [7:0]        q_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [7:0]        q_b
);

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    // No reset on the array or read registers so the block maps onto dual-port block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        if (re_a)
            q_a <= mem[ra_a];
        if (re_b)
            q_b <= mem[ra_b];
    end

endmodule

// File: rtl/cog_ram_dp.sv
// Cog register RAM: byte-enabled write port, two independent read ports, post-reset clear sequencer.
module cog_ram_dp
    import cog_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 9,
    parameter int RDW_NEW      = 1,
    parameter int CLEAR_ON_RES = 1
) (
    input  logic                clk,
    input  logic                res,
    output logic                busy,
    input  logic                ena_a,
    input  logic [ADDR_W-1:0]   a_a,
    output logic [DATA_W-1:0]   q_a,
    input  logic                ena_b,
    input  logic [ADDR_W-1:0]   a_b,
    output logic [DATA_W-1:0]   q_b,
    input  logic                w,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   a_w,
    input  logic [DATA_W-1:0]   d
);

    localparam int LANES = DATA_W / 8;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              run;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg <= (CLEAR_ON_RES != 0) ? ST_CLEAR : ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (state_reg == ST_CLEAR) begin
            cnt_next = cnt_reg + 1'b1;
            if (&cnt_reg)
                state_next = ST_RUN;
        end
    end

    assign run  = (state_reg == ST_RUN);
    assign busy = ~run;

    // Forwarding bookkeeping: the lanes always return old data, so a same-edge write is
    // remembered per port (byte mask + data) and merged onto the RAM output.
    logic              rd_a, rd_b, hit_a, hit_b;
    logic              zero_a_reg, zero_b_reg;
    logic [LANES-1:0]  fmask_a_reg, fmask_b_reg;
    logic [DATA_W-1:0] fdata_a_reg, fdata_b_reg;

    assign rd_a  = run & ena_a;
    assign rd_b  = run & ena_b;
    assign hit_a = (RDW_NEW != 0) && w && (a_a == a_w);
    assign hit_b = (RDW_NEW != 0) && w && (a_b == a_w);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            zero_a_reg  <= 1'b1;
            zero_b_reg  <= 1'b1;
            fmask_a_reg <= '0;
            fmask_b_reg <= '0;
            fdata_a_reg <= '0;
            fdata_b_reg <= '0;
        end else begin
            if (rd_a) begin
                zero_a_reg  <= 1'b0;
                fmask_a_reg <= hit_a ? be : '0;
                fdata_a_reg <= d;
            end
            if (rd_b) begin
                zero_b_reg  <= 1'b0;
                fmask_b_reg <= hit_b ? be : '0;
                fdata_b_reg <= d;
            end
        end
    end

    logic [DATA_W-1:0] ram_a, ram_b;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic       lane_we;
            logic [7:0] lane_wd;
            logic [ADDR_W-1:0] lane_wa;

            assign lane_we = busy | (w & be[gi]);
            assign lane_wa = busy ? cnt_reg : a_w;
            assign lane_wd = busy ? 8'h00 : d[8*gi +: 8];

            cog_ram_lane #(
                .ADDR_W(ADDR_W)
            ) u_lane (
                .clk  (clk),
                .we   (lane_we),
                .wa   (lane_wa),
                .wd   (lane_wd),
                .re_a (rd_a),
                .ra_a (a_a),
                .q_a  (ram_a[8*gi +: 8]),
                .re_b (rd_b),
                .ra_b (a_b),
                .q_b  (ram_b[8*gi +: 8])
            );

            assign q_a[8*gi +: 8] = zero_a_reg ? 8'h00
                                  : byte_merge(ram_a[8*gi +: 8], fdata_a_reg[8*gi +: 8], fmask_a_reg[gi]);
            assign q_b[8*gi +: 8] = zero_b_reg ? 8'h00
                                  : byte_merge(ram_b[8*gi +: 8], fdata_b_reg[8*gi +: 8], fmask_b_reg[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_cog_ram_dp.sv
// Scoreboard bench for cog_ram_dp: new-data and old-data RDW variants driven side by side.
module tb_cog_ram_dp;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        ena_a = 1'b0, ena_b = 1'b0, w = 1'b0;
    logic [8:0]  a_a = '0, a_b = '0, a_w = '0;
    logic [3:0]  be = '0;
    logic [31:0] d = '0;

    logic        busy_n, busy_o;
    logic [31:0] q_a_n, q_b_n, q_a_o, q_b_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cog_ram_dp #(.DATA_W(32), .ADDR_W(9), .RDW_NEW(1), .CLEAR_ON_RES(1)) dut (
        .clk(clk), .res(res), .busy(busy_n),
        .ena_a(ena_a), .a_a(a_a), .q_a(q_a_n),
        .ena_b(ena_b), .a_b(a_b), .q_b(q_b_n),
        .w(w), .be(be), .a_w(a_w), .d(d)
    );

    cog_ram_dp #(.DATA_W(32), .ADDR_W(9), .RDW_NEW(0), .CLEAR_ON_RES(1)) dut_old (
        .clk(clk), .res(res), .busy(busy_o),
        .ena_a(ena_a), .a_a(a_a), .q_a(q_a_o),
        .ena_b(ena_b), .a_b(a_b), .q_b(q_b_o),
        .w(w), .be(be), .a_w(a_w), .d(d)
    );

    typedef struct {
        string       name;
        logic [31:0] e_new;
        logic [31:0] e_old;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: a read accepted on a RUN edge presents its data for the following half cycle.
    logic vld_a = 1'b0, vld_b = 1'b0;
    exp_t mon_e;

    always @(posedge clk) begin
        vld_a <= ena_a && !busy_n;
        vld_b <= ena_b && !busy_n;
    end

    always @(negedge clk) begin
        if (vld_a) begin
            if (exp_a.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL port_a_unexpected: got %h, expected no read", q_a_n);
            end else begin
                mon_e = exp_a.pop_front();
                check({mon_e.name, "_a_new"}, q_a_n, mon_e.e_new);
                check({mon_e.name, "_a_old"}, q_a_o, mon_e.e_old);
            end
        end
        if (vld_b) begin
            if (exp_b.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL port_b_unexpected: got %h, expected no read", q_b_n);
            end else begin
                mon_e = exp_b.pop_front();
                check({mon_e.name, "_b_new"}, q_b_n, mon_e.e_new);
                check({mon_e.name, "_b_old"}, q_b_o, mon_e.e_old);
            end
        end
    end

    task automatic push(input bit port_b, input string name, input logic [31:0] en, input logic [31:0] eo);
        exp_t e;
        e.name = name; e.e_new = en; e.e_old = eo;
        if (port_b) exp_b.push_back(e);
        else        exp_a.push_back(e);
    endtask

    // One cycle of stimulus, applied at a falling edge and withdrawn at the next.
    task automatic cyc(input logic wi, input logic [3:0] bei, input logic [8:0] awi, input logic [31:0] di,
                       input logic ea, input logic [8:0] aa, input logic eb, input logic [8:0] ab);
        w = wi; be = bei; a_w = awi; d = di;
        ena_a = ea; a_a = aa; ena_b = eb; a_b = ab;
        @(negedge clk);
        w = 1'b0; ena_a = 1'b0; ena_b = 1'b0;
    endtask

    task automatic wait_clear(input string name);
        int cycles = 0;
        while (busy_n && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
        w = 1'b0; ena_a = 1'b0; ena_b = 1'b0;
        check({name, "_busy_cycles"}, cycles, 512);
        check({name, "_busy_old_done"}, {31'd0, busy_o}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_q_a", q_a_n, 32'h0);
        check("reset_q_b", q_b_n, 32'h0);
        check("reset_busy", {31'd0, busy_n}, 32'd1);
        res = 1'b0;
        wait_clear("clear1");

        // Freshly cleared array reads zero at both ends of the address range.
        push(0, "clr_lo", 32'h0, 32'h0);
        push(1, "clr_hi", 32'h0, 32'h0);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h000, 1, 9'h1FF);

        cyc(1, 4'hF, 9'h010, 32'hDEADBEEF, 0, 9'h000, 0, 9'h000);
        push(0, "wr_rd", 32'hDEADBEEF, 32'hDEADBEEF);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h010, 0, 9'h000);

        cyc(1, 4'hF, 9'h020, 32'h11223344, 0, 9'h000, 0, 9'h000);
        cyc(1, 4'h5, 9'h020, 32'hAABBCCDD, 0, 9'h000, 0, 9'h000);
        push(1, "byte_en", 32'h11BB33DD, 32'h11BB33DD);
        cyc(0, 4'h0, 9'h000, 32'h0, 0, 9'h000, 1, 9'h020);

        // Full-word read-during-write on both ports.
        push(0, "rdw_full", 32'h12345678, 32'h00000000);
        push(1, "rdw_full", 32'h12345678, 32'h00000000);
        cyc(1, 4'hF, 9'h030, 32'h12345678, 1, 9'h030, 1, 9'h030);
        push(0, "after_rdw", 32'h12345678, 32'h12345678);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h030, 0, 9'h000);

        // Partial read-during-write: only enabled bytes are forwarded; port B reads elsewhere.
        push(0, "rdw_part", 32'h12BBCC78, 32'h12345678);
        push(1, "rdw_other", 32'hDEADBEEF, 32'hDEADBEEF);
        cyc(1, 4'h6, 9'h030, 32'hAABBCCDD, 1, 9'h030, 1, 9'h010);
        push(1, "after_part", 32'h12BBCC78, 32'h12BBCC78);
        cyc(0, 4'h0, 9'h000, 32'h0, 0, 9'h000, 1, 9'h030);

        // Write with no byte enables changes nothing.
        cyc(1, 4'h0, 9'h010, 32'h00000000, 0, 9'h000, 0, 9'h000);
        cyc(1, 4'hF, 9'h1FF, 32'hCAFEF00D, 0, 9'h000, 0, 9'h000);
        push(0, "top_addr", 32'hCAFEF00D, 32'hCAFEF00D);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h1FF, 0, 9'h000);

        push(0, "dual", 32'hDEADBEEF, 32'hDEADBEEF);
        push(1, "dual", 32'h11BB33DD, 32'h11BB33DD);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h010, 1, 9'h020);
        cyc(0, 4'h0, 9'h000, 32'h0, 0, 9'h1FF, 0, 9'h000);
        check("hold_a_new", q_a_n, 32'hDEADBEEF);
        check("hold_a_old", q_a_o, 32'hDEADBEEF);
        check("hold_b_new", q_b_n, 32'h11BB33DD);

        // Reset in RUN, then again mid-clear with user traffic that must be ignored.
        res = 1'b1;
        #1;
        check("rst_run_q_a", q_a_n, 32'h0);
        check("rst_run_busy", {31'd0, busy_n}, 32'd1);
        @(negedge clk);
        res = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        res = 1'b1;
        #1;
        check("rst_clr_busy", {31'd0, busy_n}, 32'd1);
        check("rst_clr_q_b", q_b_n, 32'h0);
        w = 1'b1; be = 4'hF; a_w = 9'h010; d = 32'hFFFFFFFF;
        ena_a = 1'b1; a_a = 9'h010;
        @(negedge clk);
        res = 1'b0;
        wait_clear("clear2");
        check("post_clear_q_a", q_a_n, 32'h0);

        push(0, "busy_wr_ign", 32'h0, 32'h0);
        push(1, "clr_cnt100", 32'h0, 32'h0);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h010, 1, 9'h064);
        push(0, "clr_1ff", 32'h0, 32'h0);
        cyc(0, 4'h0, 9'h000, 32'h0, 1, 9'h1FF, 0, 9'h000);

        repeat (3) @(negedge clk);
        check("pending_a", exp_a.size(), 32'd0);
        check("pending_b", exp_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
